// File: rtl/fma16_vector_sequencer.sv
// ROM-driven stimulus/check sequencer for fma16: fetch, apply, check, count mismatches.
// Optional build macro FMA16_SEQ_STOP_ON_ERROR_EN ends the run at the first mismatch.
module fma16_vector_sequencer #(
    parameter int ADDR_W = 14,
    parameter int VEC_W  = 76
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   num_vectors,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [VEC_W-1:0]  mem_rdata,
    output logic [15:0]       x,
    output logic [15:0]       y,
    output logic [15:0]       z,
    output logic              mul,
    output logic              add,
    output logic              negp,
    output logic              negz,
    output logic [1:0]        roundmode,
    input  logic [15:0]       result,
    input  logic [3:0]        flags,
    output logic              busy,
    output logic              done,
    output logic [31:0]       vectornum,
    output logic [31:0]       errors,
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_index,
    output logic [15:0]       err_result,
    output logic [3:0]        err_flags
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_APPLY, S_CHECK, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       x_q, x_d, y_q, y_d, z_q, z_d;
    logic [5:0]        ctrl_q, ctrl_d;
    logic [15:0]       exp_res_q, exp_res_d;
    logic [3:0]        exp_flags_q, exp_flags_d;
    logic [31:0]       vectornum_q, vectornum_d;
    logic [31:0]       errors_q, errors_d;
    logic [ADDR_W-1:0] err_index_q, err_index_d;
    logic [15:0]       err_result_q, err_result_d;
    logic [3:0]        err_flags_q, err_flags_d;

    logic              mismatch;
    logic              last_vec;
    logic              ctrl_unused;

    // ctrl[7:6] of each vector are reserved and deliberately dropped
    assign ctrl_unused = ^mem_rdata[27:26];

    assign mismatch = ({result, flags} != {exp_res_q, exp_flags_q});
    assign last_vec = (({1'b0, idx_q} + {{ADDR_W{1'b0}}, 1'b1}) == count_q);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        count_d      = count_q;
        mem_addr_d   = mem_addr_q;
        x_d          = x_q;
        y_d          = y_q;
        z_d          = z_q;
        ctrl_d       = ctrl_q;
        exp_res_d    = exp_res_q;
        exp_flags_d  = exp_flags_q;
        vectornum_d  = vectornum_q;
        errors_d     = errors_q;
        err_index_d  = err_index_q;
        err_result_d = err_result_q;
        err_flags_d  = err_flags_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    count_d      = num_vectors;
                    idx_d        = '0;
                    vectornum_d  = '0;
                    errors_d     = '0;
                    err_index_d  = '0;
                    err_result_d = '0;
                    err_flags_d  = '0;
                    if (num_vectors == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_FETCH;
                        mem_addr_d = '0;
                    end
                end
            end
            S_FETCH: state_d = S_APPLY;
            S_APPLY: begin
                x_d         = mem_rdata[75:60];
                y_d         = mem_rdata[59:44];
                z_d         = mem_rdata[43:28];
                ctrl_d      = mem_rdata[25:20];
                exp_res_d   = mem_rdata[19:4];
                exp_flags_d = mem_rdata[3:0];
                state_d     = S_CHECK;
            end
            S_CHECK: begin
                vectornum_d = vectornum_q + 32'd1;
                idx_d       = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                if (mismatch) begin
                    errors_d     = (errors_q == 32'hFFFF_FFFF) ? errors_q : errors_q + 32'd1;
                    err_index_d  = idx_q;
                    err_result_d = result;
                    err_flags_d  = flags;
                end
`ifdef FMA16_SEQ_STOP_ON_ERROR_EN
                if (last_vec || mismatch) begin
`else
                if (last_vec) begin
`endif
                    state_d = S_DONE;
                end else begin
                    state_d    = S_FETCH;
                    mem_addr_d = idx_d;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            count_q      <= '0;
            mem_addr_q   <= '0;
            x_q          <= '0;
            y_q          <= '0;
            z_q          <= '0;
            ctrl_q       <= '0;
            exp_res_q    <= '0;
            exp_flags_q  <= '0;
            vectornum_q  <= '0;
            errors_q     <= '0;
            err_index_q  <= '0;
            err_result_q <= '0;
            err_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            mem_addr_q   <= mem_addr_d;
            x_q          <= x_d;
            y_q          <= y_d;
            z_q          <= z_d;
            ctrl_q       <= ctrl_d;
            exp_res_q    <= exp_res_d;
            exp_flags_q  <= exp_flags_d;
            vectornum_q  <= vectornum_d;
            errors_q     <= errors_d;
            err_index_q  <= err_index_d;
            err_result_q <= err_result_d;
            err_flags_q  <= err_flags_d;
        end
    end

    // err_valid must mark the CHECK cycle itself, so it is decoded rather than delayed
    assign err_valid  = (state_q == S_CHECK) && mismatch;
    assign mem_rd_en  = (state_q == S_FETCH);
    assign busy       = (state_q == S_FETCH) || (state_q == S_APPLY) || (state_q == S_CHECK);
    assign done       = (state_q == S_DONE);
    assign mem_addr   = mem_addr_q;
    assign x          = x_q;
    assign y          = y_q;
    assign z          = z_q;
    assign {roundmode, mul, add, negp, negz} = ctrl_q;
    assign vectornum  = vectornum_q;
    assign errors     = errors_q;
    assign err_index  = err_index_q;
    assign err_result = err_result_q;
    assign err_flags  = err_flags_q;

endmodule

// File: tb/tb_fma16_vector_sequencer.sv
// Scoreboard bench for fma16_vector_sequencer: ROM model, table-driven fake fma16, decoupled monitor.
module tb_fma16_vector_sequencer;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   num_vectors = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [75:0]   mem_rdata = '0;
    logic [15:0]   x, y, z;
    logic          mul, add, negp, negz;
    logic [1:0]    roundmode;
    logic [15:0]   result;
    logic [3:0]    flags;
    logic          busy, done;
    logic [31:0]   vectornum, errors;
    logic          err_valid;
    logic [AW-1:0] err_index;
    logic [15:0]   err_result;
    logic [3:0]    err_flags;

    fma16_vector_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .num_vectors(num_vectors),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .x(x), .y(y), .z(z), .mul(mul), .add(add), .negp(negp), .negz(negz),
        .roundmode(roundmode), .result(result), .flags(flags),
        .busy(busy), .done(done), .vectornum(vectornum), .errors(errors),
        .err_valid(err_valid), .err_index(err_index), .err_result(err_result),
        .err_flags(err_flags)
    );

    always #5 clk = ~clk;

    logic [75:0]   rom  [0:16383];
    logic [15:0]   fres [0:16383];
    logic [3:0]    fflg [0:16383];
    logic [AW-1:0] cur_addr = '0;

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= rom[mem_addr];
            cur_addr  <= mem_addr;
        end
    end
    // Stand-in for fma16: returns the tabled answer for the vector last fetched
    assign result = fres[cur_addr];
    assign flags  = fflg[cur_addr];

    typedef struct {
        int          vn;
        int          errs;
        int          lat;
        logic [13:0] eidx;
        logic [15:0] eres;
        logic [3:0]  eflg;
    } run_t;
    typedef struct {
        logic [13:0] idx;
        logic [15:0] res;
        logic [3:0]  flg;
    } err_t;

    run_t run_q[$];
    err_t err_q[$];
    int   checks = 0;
    int   fails = 0;
    int   done_events = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [75:0] mkvec(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input logic [7:0] ct,
                                          input logic [15:0] r, input logic [3:0] f);
        return {a, b, c, ct, r, f};
    endfunction

    task automatic setv(input int i, input logic [75:0] v, input logic [15:0] ar, input logic [3:0] af);
        rom[i]  = v;
        fres[i] = ar;
        fflg[i] = af;
    endtask

    task automatic run(input int n, input int vn, input int errs, input int lat,
                       input logic [13:0] eidx, input logic [15:0] eres, input logic [3:0] eflg,
                       input int mid_start);
        int ev;
        int k;
        run_q.push_back('{vn: vn, errs: errs, lat: lat, eidx: eidx, eres: eres, eflg: eflg});
        ev = done_events;
        @(posedge clk); #1;
        start = 1'b1;
        num_vectors = (AW+1)'(n);
        @(posedge clk); #1;
        start = 1'b0;
        if (mid_start > 0) begin
            repeat (mid_start) @(posedge clk);
            #1;
            start = 1'b1;
            num_vectors = (AW+1)'(1);
            @(posedge clk); #1;
            start = 1'b0;
        end
        k = 0;
        while (done_events == ev && k < 3 * n + 40) begin
            @(negedge clk);
            k++;
        end
        if (done_events == ev) begin
            chk("run_timeout", 64'(done_events), 64'(ev + 1));
            run_q.delete();
            err_q.delete();
        end
    endtask

    // Monitor: checks fetch addresses, applied operands, error pulses and run summaries
    initial begin
        int          cyc = 0;
        int          rd = 0;
        logic        s1 = 0, s2 = 0, pend = 0, pdone = 0, pstart = 0;
        logic [13:0] a1 = 0, a2 = 0, alast = 0;
        err_t        pe;
        run_t        r;
        forever begin
            @(negedge clk);
            if (!reset) begin
                s1 = 0; s2 = 0; pend = 0; pdone = 0; pstart = 0; cyc = 0; rd = 0;
                continue;
            end
            cyc++;
            if (pend) begin
                chk("err_index", 64'(err_index), 64'(pe.idx));
                chk("err_result", 64'(err_result), 64'(pe.res));
                chk("err_flags", 64'(err_flags), 64'(pe.flg));
                pend = 0;
            end
            if (err_valid) begin
                if (err_q.size() == 0) begin
                    chk("unexpected_err_valid", 64'(err_valid), 64'(0));
                end else begin
                    pe = err_q.pop_front();
                    pend = 1;
                end
            end
            if (s2) begin
                chk("x_applied", 64'(x), 64'(rom[a2][75:60]));
                chk("y_applied", 64'(y), 64'(rom[a2][59:44]));
                chk("z_applied", 64'(z), 64'(rom[a2][43:28]));
                chk("ctrl_applied", 64'({roundmode, mul, add, negp, negz}), 64'(rom[a2][25:20]));
            end
            s2 = s1;
            a2 = a1;
            if (done && (!pdone || pstart)) begin
                done_events++;
                if (run_q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'(0));
                end else begin
                    r = run_q.pop_front();
                    chk("vectornum", 64'(vectornum), 64'(r.vn));
                    chk("errors", 64'(errors), 64'(r.errs));
                    chk("latency", 64'(cyc), 64'(r.lat));
                    chk("fetch_count", 64'(rd), 64'(r.vn));
                    chk("done_err_index", 64'(err_index), 64'(r.eidx));
                    chk("done_err_result", 64'(err_result), 64'(r.eres));
                    chk("done_err_flags", 64'(err_flags), 64'(r.eflg));
                    chk("busy_in_done", 64'(busy), 64'(0));
                    chk("missing_err_pulses", 64'(err_q.size()), 64'(0));
                    if (r.vn > 0) chk("x_hold", 64'(x), 64'(rom[alast][75:60]));
                end
            end
            if (mem_rd_en) begin
                chk("mem_addr", 64'(mem_addr), 64'(rd));
                a1 = mem_addr;
                alast = mem_addr;
                rd++;
            end
            s1 = mem_rd_en;
            if (start && !busy) begin
                cyc = 0;
                rd = 0;
            end
            pdone = done;
            pstart = start;
        end
    end

    initial begin
        int k;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy_done", 64'({busy, done}), 64'(0));
        chk("rst_vectornum", 64'(vectornum), 64'(0));
        chk("rst_errors", 64'(errors), 64'(0));
        chk("rst_operands", 64'({x, y, z}), 64'(0));
        chk("rst_ctrl_rd", 64'({roundmode, mul, add, negp, negz, mem_rd_en, mem_addr}), 64'(0));
        chk("rst_err", 64'({err_valid, err_index, err_result, err_flags}), 64'(0));
        reset = 1'b1;

        // two passing vectors: 1.0*2.0 and 1.0*1.0+1.0
        setv(0, mkvec(16'h3C00, 16'h4000, 16'h0000, 8'h08, 16'h4000, 4'h0), 16'h4000, 4'h0);
        setv(1, mkvec(16'h3C00, 16'h3C00, 16'h3C00, 8'h0C, 16'h4000, 4'h0), 16'h4000, 4'h0);
        run(2, 2, 0, 7, 14'd0, 16'h0, 4'h0, 0);

        // result mismatch on vector 1
        setv(1, mkvec(16'h3C00, 16'h3C00, 16'h3C00, 8'h0C, 16'h4001, 4'h0), 16'h4000, 4'h0);
        setv(2, mkvec(16'h4000, 16'h3C00, 16'h0000, 8'h08, 16'h4000, 4'h0), 16'h4000, 4'h0);
        err_q.push_back('{idx: 14'd1, res: 16'h4000, flg: 4'h0});
`ifdef FMA16_SEQ_STOP_ON_ERROR_EN
        run(3, 2, 1, 7, 14'd1, 16'h4000, 4'h0, 0);
`else
        run(3, 3, 1, 10, 14'd1, 16'h4000, 4'h0, 0);
`endif

        // flags-only mismatch on vector 2
        setv(1, mkvec(16'h3C00, 16'h3C00, 16'h3C00, 8'h0C, 16'h4000, 4'h0), 16'h4000, 4'h0);
        setv(2, mkvec(16'h4000, 16'h3C00, 16'h0000, 8'hF8, 16'h4000, 4'h1), 16'h4000, 4'h0);
        err_q.push_back('{idx: 14'd2, res: 16'h4000, flg: 4'h0});
        run(3, 3, 1, 10, 14'd2, 16'h4000, 4'h0, 0);

        // restart from DONE clears the error capture
        run(2, 2, 0, 7, 14'd0, 16'h0, 4'h0, 0);

        // zero-length run
        run(0, 0, 0, 1, 14'd0, 16'h0, 4'h0, 0);

        // start pulsed mid-run is ignored
        setv(2, mkvec(16'h4200, 16'h4400, 16'h3C00, 8'h35, 16'h4E00, 4'h0), 16'h4E00, 4'h0);
        setv(3, mkvec(16'h7C00, 16'hFC00, 16'h0000, 8'h2A, 16'h7E00, 4'h8), 16'h7E00, 4'h8);
        run(4, 4, 0, 13, 14'd0, 16'h0, 4'h0, 3);

        // asynchronous reset while vector 3 of 10 is in flight
        for (int i = 0; i < 10; i++)
            setv(i, mkvec(16'(i), 16'h3C00, 16'(i + 7), 8'(i), 16'h1000 + 16'(i), 4'(i)),
                 16'h1000 + 16'(i), 4'(i));
        @(posedge clk); #1;
        start = 1'b1;
        num_vectors = (AW+1)'(10);
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (vectornum != 32'd3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("reached_vector3", 64'(vectornum), 64'(3));
        #2 reset = 1'b0;
        #1;
        chk("midrst_busy_done", 64'({busy, done}), 64'(0));
        chk("midrst_counts", 64'({vectornum, errors}), 64'(0));
        chk("midrst_operands", 64'({x, y, z}), 64'(0));
        chk("midrst_ctrl_rd", 64'({roundmode, mul, add, negp, negz, mem_rd_en, mem_addr}), 64'(0));
        repeat (2) @(posedge clk);
        run_q.delete();
        err_q.delete();
        #1 reset = 1'b1;
        run(2, 2, 0, 7, 14'd0, 16'h0, 4'h0, 0);

        // full address space, no wrap
        for (int i = 0; i < 16384; i++)
            setv(i, mkvec(16'(i), ~16'(i), 16'(i * 3), 8'(i), 16'h1234 ^ 16'(i), 4'(i)),
                 16'h1234 ^ 16'(i), 4'(i));
        run(16384, 16384, 0, 49153, 14'd0, 16'h0, 4'h0, 0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
